// File: rtl/rob_if.sv
// Reorder buffer bus: dispatch allocation, result writeback, operand lookup,
// in-order commit and mispredict recovery, bundled for one connection.
interface rob_if #(
  parameter int ROB_ID_WIDTH = 4
);
  logic                    alloc_valid;
  logic [4:0]              alloc_rd;
  logic                    alloc_ready;
  logic [ROB_ID_WIDTH-1:0] alloc_rob_id;

  logic                    cdb_valid;
  logic [ROB_ID_WIDTH-1:0] cdb_rob_id;
  logic [31:0]             cdb_value;
  logic                    cdb_mispredict;
  logic [31:0]             cdb_redirect_pc;

  logic [ROB_ID_WIDTH-1:0] q1_rob_id;
  logic [ROB_ID_WIDTH-1:0] q2_rob_id;
  logic                    q1_ready;
  logic                    q2_ready;
  logic [31:0]             q1_value;
  logic [31:0]             q2_value;

  logic                    commit_we;
  logic [4:0]              commit_addr;
  logic [ROB_ID_WIDTH-1:0] commit_rob_id;
  logic [31:0]             commit_value;

  logic                    flush;
  logic [31:0]             redirect_pc;

  modport master (
    output alloc_valid, alloc_rd,
    output cdb_valid, cdb_rob_id, cdb_value, cdb_mispredict, cdb_redirect_pc,
    output q1_rob_id, q2_rob_id,
    input  alloc_ready, alloc_rob_id,
    input  q1_ready, q2_ready, q1_value, q2_value,
    input  commit_we, commit_addr, commit_rob_id, commit_value,
    input  flush, redirect_pc
  );

  modport slave (
    input  alloc_valid, alloc_rd,
    input  cdb_valid, cdb_rob_id, cdb_value, cdb_mispredict, cdb_redirect_pc,
    input  q1_rob_id, q2_rob_id,
    output alloc_ready, alloc_rob_id,
    output q1_ready, q2_ready, q1_value, q2_value,
    output commit_we, commit_addr, commit_rob_id, commit_value,
    output flush, redirect_pc
  );
endinterface

// File: rtl/rob.sv
// Reorder buffer: circular queue of in-flight results, retired in program
// order one per cycle; a mispredicting head commits and then flushes everything.
module rob #(
  parameter int ROB_DEPTH    = 16,
  parameter int ROB_ID_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  rob_if.slave bus
);
  localparam logic [ROB_ID_WIDTH:0] FULL = (ROB_ID_WIDTH+1)'(ROB_DEPTH);

  logic [ROB_ID_WIDTH-1:0] head;
  logic [ROB_ID_WIDTH-1:0] tail;
  logic [ROB_ID_WIDTH:0]   count;

  logic [ROB_DEPTH-1:0] busy;
  logic [ROB_DEPTH-1:0] rdy;
  logic [ROB_DEPTH-1:0] mispred;
  logic [4:0]           rd_q  [ROB_DEPTH];
  logic [31:0]          val_q [ROB_DEPTH];
  logic [31:0]          rpc_q [ROB_DEPTH];

  logic alloc_ok;
  logic do_alloc;
  logic do_wb;
  logic do_commit;
  logic do_flush;

  // Commit is decided from registered head state only, so a result written
  // back this cycle cannot retire before the next one.
  assign do_commit = (count != '0) && rdy[head];
  assign do_flush  = do_commit && mispred[head];
  assign alloc_ok  = (count != FULL) && !do_flush;
  assign do_alloc  = bus.alloc_valid && alloc_ok;
  assign do_wb     = bus.cdb_valid && busy[bus.cdb_rob_id];

  assign bus.alloc_ready  = alloc_ok;
  assign bus.alloc_rob_id = tail;

  // Pointer, occupancy and per-entry status bits; flush wins over all else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      busy    <= '0;
      rdy     <= '0;
      mispred <= '0;
    end else if (do_flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      busy    <= '0;
      rdy     <= '0;
      mispred <= '0;
    end else begin
      if (do_alloc) begin
        busy[tail]    <= 1'b1;
        rdy[tail]     <= 1'b0;
        mispred[tail] <= 1'b0;
        tail          <= tail + 1'b1;
      end
      if (do_wb) begin
        rdy[bus.cdb_rob_id]     <= 1'b1;
        mispred[bus.cdb_rob_id] <= bus.cdb_mispredict;
      end
      // Placed last so a redundant writeback to the retiring head cannot
      // leave a stale ready bit behind.
      if (do_commit) begin
        busy[head] <= 1'b0;
        rdy[head]  <= 1'b0;
        head       <= head + 1'b1;
      end
      if (do_alloc && !do_commit) begin
        count <= count + 1'b1;
      end else if (!do_alloc && do_commit) begin
        count <= count - 1'b1;
      end
    end
  end

  // Payload storage; only meaningful while the matching status bits say so.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      rd_q[tail] <= bus.alloc_rd;
    end
    if (do_wb) begin
      val_q[bus.cdb_rob_id] <= bus.cdb_value;
      rpc_q[bus.cdb_rob_id] <= bus.cdb_redirect_pc;
    end
  end

  // Operand lookup with same-cycle writeback forwarding.
  always_comb begin
    bus.q1_ready = rdy[bus.q1_rob_id];
    bus.q1_value = val_q[bus.q1_rob_id];
    bus.q2_ready = rdy[bus.q2_rob_id];
    bus.q2_value = val_q[bus.q2_rob_id];
    if (bus.cdb_valid && (bus.cdb_rob_id == bus.q1_rob_id)) begin
      bus.q1_ready = 1'b1;
      bus.q1_value = bus.cdb_value;
    end
    if (bus.cdb_valid && (bus.cdb_rob_id == bus.q2_rob_id)) begin
      bus.q2_ready = 1'b1;
      bus.q2_value = bus.cdb_value;
    end
  end

  // Commit and recovery outputs, forced to zero when nothing retires.
  always_comb begin
    bus.commit_we     = 1'b0;
    bus.commit_addr   = '0;
    bus.commit_rob_id = '0;
    bus.commit_value  = '0;
    bus.flush         = 1'b0;
    bus.redirect_pc   = '0;
    if (do_commit) begin
      bus.commit_we     = 1'b1;
      bus.commit_addr   = rd_q[head];
      bus.commit_rob_id = head;
      bus.commit_value  = val_q[head];
    end
    if (do_flush) begin
      bus.flush       = 1'b1;
      bus.redirect_pc = rpc_q[head];
    end
  end
endmodule

// File: tb/tb_rob.sv
// Bench for the reorder buffer: a directed vector table, hand-written
// full/flush/reset/overlap sequences, then random traffic against a queue model.
module tb_rob;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  rob_if #(.ROB_ID_WIDTH(4)) bus();

  rob #(.ROB_DEPTH(16), .ROB_ID_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic        cv;
    logic [3:0]  cid;
    logic [31:0] cval;
    logic        cmis;
    logic [31:0] cpc;
    logic [3:0]  q1;
    logic        e_ar;
    logic [3:0]  e_aid;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [3:0]  e_cid;
    logic [31:0] e_cval;
    logic        e_fl;
    logic [31:0] e_rpc;
    logic        e_q1r;
    logic [31:0] e_q1v;
  } vec_t;

  vec_t tbl[16];

  // Reference model: in-flight entries in program order.
  typedef struct {
    int          id;
    logic [4:0]  rd;
    bit          rdy;
    logic [31:0] val;
    bit          mis;
    logic [31:0] pc;
  } ment_t;

  ment_t mq[$];
  int    m_tail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] rd, input logic cv,
                       input logic [3:0] cid, input logic [31:0] cval, input logic cmis,
                       input logic [31:0] cpc, input logic [3:0] q1, input logic [3:0] q2);
    @(negedge clk);
    bus.alloc_valid     = av;
    bus.alloc_rd        = rd;
    bus.cdb_valid       = cv;
    bus.cdb_rob_id      = cid;
    bus.cdb_value       = cval;
    bus.cdb_mispredict  = cmis;
    bus.cdb_redirect_pc = cpc;
    bus.q1_rob_id       = q1;
    bus.q2_rob_id       = q2;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.alloc_valid = 1'b0;
    bus.cdb_valid   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_tail = 0;
  endtask

  function automatic int mfind(input int id);
    foreach (mq[k]) if (mq[k].id == id) return k;
    return -1;
  endfunction

  function automatic void mlook(input int qid, input logic cv, input int cid,
                                input logic [31:0] cval, output bit r, output logic [31:0] v);
    int k;
    r = 1'b0;
    v = '0;
    k = mfind(qid);
    if (cv && (cid == qid)) begin
      r = 1'b1;
      v = cval;
    end else if (k >= 0 && mq[k].rdy) begin
      r = 1'b1;
      v = mq[k].val;
    end
  endfunction

  logic        r_av, r_cv, r_cmis;
  logic [4:0]  r_rd;
  logic [3:0]  r_cid, r_q1, r_q2;
  logic [31:0] r_cval, r_cpc, e_v;
  bit          e_com, e_fl, e_ar, e_r;
  int          k;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.alloc_valid = 1'b0; bus.alloc_rd = '0;
    bus.cdb_valid = 1'b0; bus.cdb_rob_id = '0; bus.cdb_value = '0;
    bus.cdb_mispredict = 1'b0; bus.cdb_redirect_pc = '0;
    bus.q1_rob_id = '0; bus.q2_rob_id = '0;

    // Reset state while rst is held
    #3;
    chk("rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("rst_alloc_rob_id", 32'(bus.alloc_rob_id), 32'd0);
    chk("rst_commit_we", 32'(bus.commit_we), 32'd0);
    chk("rst_commit_value", bus.commit_value, 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_q1_ready", 32'(bus.q1_ready), 32'd0);
    do_reset();

    // Directed vector table: in-order commit of out-of-order results, bypass
    tbl[0]  = '{1,5,0,0,0,0,0,0,      1,0,0,0,0,0,0,0,0,0};
    tbl[1]  = '{1,6,0,0,0,0,0,0,      1,1,0,0,0,0,0,0,0,0};
    tbl[2]  = '{0,0,1,1,'h22,0,0,1,   1,2,0,0,0,0,0,0,1,'h22};
    tbl[3]  = '{0,0,1,0,'h11,0,0,1,   1,2,0,0,0,0,0,0,1,'h22};
    tbl[4]  = '{0,0,0,0,0,0,0,0,      1,2,1,5,0,'h11,0,0,1,'h11};
    tbl[5]  = '{0,0,0,0,0,0,0,0,      1,2,1,6,1,'h22,0,0,0,0};
    tbl[6]  = '{0,0,0,0,0,0,0,1,      1,2,0,0,0,0,0,0,0,0};
    tbl[7]  = '{1,7,0,0,0,0,0,2,      1,2,0,0,0,0,0,0,0,0};
    tbl[8]  = '{1,8,0,0,0,0,0,2,      1,3,0,0,0,0,0,0,0,0};
    tbl[9]  = '{1,9,0,0,0,0,0,2,      1,4,0,0,0,0,0,0,0,0};
    tbl[10] = '{0,0,1,3,'hABCD,0,0,3, 1,5,0,0,0,0,0,0,1,'hABCD};
    tbl[11] = '{0,0,0,0,0,0,0,3,      1,5,0,0,0,0,0,0,1,'hABCD};
    tbl[12] = '{0,0,1,2,'h77,0,0,2,   1,5,0,0,0,0,0,0,1,'h77};
    tbl[13] = '{0,0,0,0,0,0,0,4,      1,5,1,7,2,'h77,0,0,0,0};
    tbl[14] = '{0,0,0,0,0,0,0,4,      1,5,1,8,3,'hABCD,0,0,0,0};
    tbl[15] = '{0,0,0,0,0,0,0,4,      1,5,0,0,0,0,0,0,0,0};

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].av, tbl[i].ard, tbl[i].cv, tbl[i].cid, tbl[i].cval,
            tbl[i].cmis, tbl[i].cpc, tbl[i].q1, 4'd0);
      chk($sformatf("tbl%0d_alloc_ready", i), 32'(bus.alloc_ready), 32'(tbl[i].e_ar));
      chk($sformatf("tbl%0d_alloc_rob_id", i), 32'(bus.alloc_rob_id), 32'(tbl[i].e_aid));
      chk($sformatf("tbl%0d_commit_we", i), 32'(bus.commit_we), 32'(tbl[i].e_we));
      chk($sformatf("tbl%0d_commit_addr", i), 32'(bus.commit_addr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_commit_rob_id", i), 32'(bus.commit_rob_id), 32'(tbl[i].e_cid));
      chk($sformatf("tbl%0d_commit_value", i), bus.commit_value, tbl[i].e_cval);
      chk($sformatf("tbl%0d_flush", i), 32'(bus.flush), 32'(tbl[i].e_fl));
      chk($sformatf("tbl%0d_redirect_pc", i), bus.redirect_pc, tbl[i].e_rpc);
      chk($sformatf("tbl%0d_q1_ready", i), 32'(bus.q1_ready), 32'(tbl[i].e_q1r));
      if (tbl[i].e_q1r) chk($sformatf("tbl%0d_q1_value", i), bus.q1_value, tbl[i].e_q1v);
    end

    // Full buffer, commit while full, wrap of the allocation ID
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 5'(i + 1), 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0);
      chk("fill_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    end
    idle();
    chk("full_alloc_ready", 32'(bus.alloc_ready), 32'd0);
    chk("full_alloc_rob_id", 32'(bus.alloc_rob_id), 32'd0);
    drive(1'b1, 5'd31, 1'b1, 4'd0, 32'h5, 1'b0, 32'd0, 4'd0, 4'd0);
    chk("full_wb_alloc_ready", 32'(bus.alloc_ready), 32'd0);
    drive(1'b1, 5'd30, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0);
    chk("full_commit_we", 32'(bus.commit_we), 32'd1);
    chk("full_commit_addr", 32'(bus.commit_addr), 32'd1);
    chk("full_commit_value", bus.commit_value, 32'h5);
    chk("full_commit_alloc_ready", 32'(bus.alloc_ready), 32'd0);
    idle();
    chk("after_full_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("after_full_alloc_rob_id", 32'(bus.alloc_rob_id), 32'd0);
    chk("after_full_commit_we", 32'(bus.commit_we), 32'd0);

    // Mispredict: commit + flush in one cycle, then empty; late CDB ignored
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 5'(10 + i), 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0);
    drive(1'b0, 5'd0, 1'b1, 4'd0, 32'h11, 1'b1, 32'h100, 4'd0, 4'd0);
    drive(1'b1, 5'd20, 1'b1, 4'd2, 32'h22, 1'b0, 32'd0, 4'd2, 4'd0);
    chk("mp_commit_we", 32'(bus.commit_we), 32'd1);
    chk("mp_commit_rob_id", 32'(bus.commit_rob_id), 32'd0);
    chk("mp_commit_addr", 32'(bus.commit_addr), 32'd10);
    chk("mp_commit_value", bus.commit_value, 32'h11);
    chk("mp_flush", 32'(bus.flush), 32'd1);
    chk("mp_redirect_pc", bus.redirect_pc, 32'h100);
    chk("mp_alloc_ready", 32'(bus.alloc_ready), 32'd0);
    drive(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd2, 4'd0);
    chk("mp_next_alloc_rob_id", 32'(bus.alloc_rob_id), 32'd0);
    chk("mp_next_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("mp_next_flush", 32'(bus.flush), 32'd0);
    chk("mp_next_redirect_pc", bus.redirect_pc, 32'd0);
    chk("mp_next_commit_we", 32'(bus.commit_we), 32'd0);
    chk("mp_next_q1_ready", 32'(bus.q1_ready), 32'd0);
    drive(1'b0, 5'd0, 1'b1, 4'd2, 32'h33, 1'b0, 32'd0, 4'd0, 4'd0);
    drive(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd2, 4'd0);
    chk("late_cdb_q1_ready", 32'(bus.q1_ready), 32'd0);
    chk("late_cdb_commit_we", 32'(bus.commit_we), 32'd0);

    // Asynchronous reset between edges with a commit pending
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, 5'(i + 1), 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0);
    drive(1'b0, 5'd0, 1'b1, 4'd0, 32'h99, 1'b0, 32'd0, 4'd0, 4'd0);
    idle();
    chk("pre_rst_commit_we", 32'(bus.commit_we), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_alloc_rob_id", 32'(bus.alloc_rob_id), 32'd0);
    chk("async_rst_commit_we", 32'(bus.commit_we), 32'd0);
    chk("async_rst_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("async_rst_q1_ready", 32'(bus.q1_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("post_rst_commit_we", 32'(bus.commit_we), 32'd0);
      chk("post_rst_alloc_rob_id", 32'(bus.alloc_rob_id), 32'd0);
    end

    // Simultaneous alloc and commit at occupancy 8
    do_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, 5'(i + 1), 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0);
    drive(1'b0, 5'd0, 1'b1, 4'd0, 32'h40, 1'b0, 32'd0, 4'd0, 4'd0);
    drive(1'b1, 5'd20, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0);
    chk("ovl_commit_we", 32'(bus.commit_we), 32'd1);
    chk("ovl_commit_rob_id", 32'(bus.commit_rob_id), 32'd0);
    chk("ovl_alloc_rob_id", 32'(bus.alloc_rob_id), 32'd8);
    chk("ovl_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    idle();
    chk("ovl_next_alloc_rob_id", 32'(bus.alloc_rob_id), 32'd9);
    chk("ovl_next_commit_we", 32'(bus.commit_we), 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'd3, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'd0, 4'd0);
      chk("ovl_fill_alloc_ready", 32'(bus.alloc_ready), 32'd1);
    end
    idle();
    chk("ovl_full_alloc_ready", 32'(bus.alloc_ready), 32'd0);
    drive(1'b0, 5'd0, 1'b1, 4'd1, 32'h41, 1'b0, 32'd0, 4'd0, 4'd0);
    idle();
    chk("ovl_head_commit_rob_id", 32'(bus.commit_rob_id), 32'd1);
    chk("ovl_head_commit_value", bus.commit_value, 32'h41);

    // Random traffic against the queue model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      r_av   = ($urandom_range(0, 9) < 7);
      r_rd   = 5'($urandom);
      r_cv   = ($urandom_range(0, 9) < 4);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        r_cid = 4'(mq[$urandom_range(0, mq.size() - 1)].id);
      else
        r_cid = 4'($urandom);
      r_cval = $urandom;
      r_cmis = ($urandom_range(0, 39) == 0);
      r_cpc  = $urandom;
      r_q1   = 4'($urandom);
      r_q2   = ($urandom_range(0, 1) == 1) ? r_cid : 4'($urandom);
      drive(r_av, r_rd, r_cv, r_cid, r_cval, r_cmis, r_cpc, r_q1, r_q2);

      e_com = (mq.size() > 0) && mq[0].rdy;
      e_fl  = e_com && mq[0].mis;
      e_ar  = (mq.size() != 16) && !e_fl;
      chk("rnd_alloc_ready", 32'(bus.alloc_ready), 32'(e_ar));
      chk("rnd_alloc_rob_id", 32'(bus.alloc_rob_id), 32'(m_tail));
      chk("rnd_commit_we", 32'(bus.commit_we), 32'(e_com));
      chk("rnd_commit_addr", 32'(bus.commit_addr), e_com ? 32'(mq[0].rd) : 32'd0);
      chk("rnd_commit_rob_id", 32'(bus.commit_rob_id), e_com ? 32'(mq[0].id) : 32'd0);
      chk("rnd_commit_value", bus.commit_value, e_com ? mq[0].val : 32'd0);
      chk("rnd_flush", 32'(bus.flush), 32'(e_fl));
      chk("rnd_redirect_pc", bus.redirect_pc, e_fl ? mq[0].pc : 32'd0);
      mlook(int'(r_q1), r_cv, int'(r_cid), r_cval, e_r, e_v);
      chk("rnd_q1_ready", 32'(bus.q1_ready), 32'(e_r));
      if (e_r) chk("rnd_q1_value", bus.q1_value, e_v);
      mlook(int'(r_q2), r_cv, int'(r_cid), r_cval, e_r, e_v);
      chk("rnd_q2_ready", 32'(bus.q2_ready), 32'(e_r));
      if (e_r) chk("rnd_q2_value", bus.q2_value, e_v);

      if (e_fl) begin
        mq.delete();
        m_tail = 0;
      end else begin
        if (r_cv) begin
          k = mfind(int'(r_cid));
          if (k >= 0) begin
            mq[k].rdy = 1'b1;
            mq[k].val = r_cval;
            mq[k].mis = r_cmis;
            mq[k].pc  = r_cpc;
          end
        end
        if (r_av && e_ar) begin
          mq.push_back('{m_tail, r_rd, 1'b0, 32'd0, 1'b0, 32'd0});
          m_tail = (m_tail + 1) % 16;
        end
        if (e_com) void'(mq.pop_front());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
